// File: rtl/mem_access_unit_if.sv
// Core-side request/response bus of the data-memory access unit.
//   req_valid/req_ready : request handshake (core -> unit)
//   req_write           : 1 = store, 0 = load
//   req_wide            : 1 = 16-bit access, 0 = byte access
//   req_addr            : byte address of the low byte
//   req_wdata           : store data (byte stores use the low byte)
//   rsp_valid           : one-cycle completion pulse (unit -> core)
//   rsp_rdata           : load result, held until the next load completes
// Modports: master = core (requester), slave = access unit.
interface mem_access_unit_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic                    req_wide;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [2*DATA_WIDTH-1:0] req_wdata;
  logic                    rsp_valid;
  logic [2*DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_wide, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_wide, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Requester-side controller for the byte-organised data memory.
// Accepts byte/16-bit loads and stores from the core, sequences the byte
// reads of the 8-bit registered read port, assembles 16-bit load results
// and performs read-modify-write for byte stores so the neighbouring byte
// written by the 2-byte write port is preserved.
// Ports:
//   clk, rst    : clock (rising edge), synchronous active-high reset
//   core        : request/response bus (slave side)
//   mem_we      : memory write enable (only in WR)
//   mem_w_addr  : write address (low byte), 0 outside WR
//   mem_w_data  : write data {hi, lo}, 0 outside WR
//   mem_r_addr  : read address
//   mem_r_data  : registered read data, valid the cycle after mem_r_addr
module mem_access_unit #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  mem_access_unit_if.slave        core,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_w_addr,
  output logic [2*DATA_WIDTH-1:0] mem_w_data,
  output logic [ADDR_WIDTH-1:0]   mem_r_addr,
  input  logic [DATA_WIDTH-1:0]   mem_r_data
);

  typedef enum logic [2:0] {
    IDLE,
    RD0,
    RD1,
    RD2,
    WR,
    RESP
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [2*DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                    write_q, write_d;
  logic                    wide_q, wide_d;
  // First byte read back: low byte of a wide load, or the preserved high
  // byte of a byte store.
  logic [DATA_WIDTH-1:0]   byte_q, byte_d;
  logic [2*DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [ADDR_WIDTH-1:0]   addr_inc;
  logic                    accept;

  assign addr_inc       = addr_q + ADDR_WIDTH'(1);
  assign accept         = core.req_valid && (state_q == IDLE);
  assign core.req_ready = (state_q == IDLE);
  assign core.rsp_rdata = rdata_q;

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    write_d        = write_q;
    wide_d         = wide_q;
    byte_d         = byte_q;
    rdata_d        = rdata_q;
    mem_we         = 1'b0;
    mem_w_addr     = '0;
    mem_w_data     = '0;
    mem_r_addr     = addr_q;
    core.rsp_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = core.req_addr;
          wdata_d = core.req_wdata;
          write_d = core.req_write;
          wide_d  = core.req_wide;
          // Wide stores need no read; everything else starts reading.
          state_d = (core.req_write && core.req_wide) ? WR : RD0;
        end
      end
      RD0: begin
        // Only byte stores reach RD0 with write set: fetch the neighbour.
        if (write_q) mem_r_addr = addr_inc;
        state_d = RD1;
      end
      RD1: begin
        if (write_q) begin
          byte_d  = mem_r_data;
          state_d = WR;
        end else if (wide_q) begin
          byte_d     = mem_r_data;
          mem_r_addr = addr_inc;
          state_d    = RD2;
        end else begin
          rdata_d                 = '0;
          rdata_d[DATA_WIDTH-1:0] = mem_r_data;
          state_d                 = RESP;
        end
      end
      RD2: begin
        rdata_d = {mem_r_data, byte_q};
        state_d = RESP;
      end
      WR: begin
        mem_we     = 1'b1;
        mem_w_addr = addr_q;
        mem_w_data = wide_q ? wdata_q : {byte_q, wdata_q[DATA_WIDTH-1:0]};
        state_d    = RESP;
      end
      RESP: begin
        core.rsp_valid = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      wide_q  <= 1'b0;
      byte_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      wide_q  <= wide_d;
      byte_q  <= byte_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Requester-side controller for the byte-organised data memory. The memory provides a 2-byte little-endian write port and an 8-bit registered read port, and it reads only in cycles where it is not writing.
- Accepts byte or 16-bit load/store requests from the core through a valid/ready handshake.
- Sequences the byte reads, assembles 16-bit load results, and performs read-modify-write for byte stores so the neighbouring byte is preserved.
- Sits between the core datapath and the data memory.

Parameters:
- DATA_WIDTH, 8, memory byte width; the access word is 2*DATA_WIDTH.
- ADDR_WIDTH, 8, memory address width; all address arithmetic is modulo 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request
- req_write  input  1  1 = store, 0 = load
- req_wide  input  1  1 = 16-bit access, 0 = byte access
- req_addr  input  ADDR_WIDTH  byte address of the low byte
- req_wdata  input  2*DATA_WIDTH  store data; byte stores use bits [DATA_WIDTH-1:0]
- rsp_valid  output  1  one-cycle completion pulse
- rsp_rdata  output  2*DATA_WIDTH  load result
- mem_we  output  1  memory write enable
- mem_w_addr  output  ADDR_WIDTH  memory write address
- mem_w_data  output  2*DATA_WIDTH  memory write data {hi, lo}
- mem_r_addr  output  ADDR_WIDTH  memory read address
- mem_r_data  input  DATA_WIDTH  memory registered read data, valid the cycle after mem_r_addr is presented with mem_we=0

Behaviour:
- One clock (clk). Reset is synchronous, active-high (rst).
- Reset values:
  - state = IDLE, so req_ready = 1.
  - rsp_valid = 0, rsp_rdata = 0, mem_we = 0, mem_w_addr = 0, mem_w_data = 0, mem_r_addr = 0.
- Handshake:
  - req_ready = 1 only in IDLE.
  - A request is accepted on a rising edge where req_valid & req_ready. At acceptance, addr, wdata, write and wide are latched.
  - req_valid while busy is ignored; the request is neither queued nor dropped with a response.
- Response:
  - rsp_valid is high for exactly one cycle, in state RESP. There is no backpressure.
  - rsp_rdata is updated only by loads and holds its value otherwise, including after stores.
- States: IDLE, RD0, RD1, RD2, WR, RESP. mem_we = 1 only in WR.
- mem_r_addr:
  - Default: the latched addr.
  - Byte store, RD0: addr+1.
  - Wide load, RD1: addr+1.
- Wide load (accept = cycle 0, rsp_valid in cycle 4):
  - RD0: present addr.
  - RD1: lo <= mem_r_data; present addr+1.
  - RD2: hi <= mem_r_data.
  - RESP: rsp_rdata = {hi, lo}.
- Byte load (rsp_valid in cycle 3):
  - RD0: present addr.
  - RD1: capture lo.
  - RESP: rsp_rdata = {0, lo}.
- Wide store (rsp_valid in cycle 2):
  - WR: mem_w_addr = addr, mem_w_data = wdata.
  - RESP.
- Byte store, read-modify-write (rsp_valid in cycle 4):
  - RD0: present addr+1.
  - RD1: capture hi.
  - WR: mem_w_data = {hi, wdata[DATA_WIDTH-1:0]} at addr.
  - RESP.
- Transitions:
  - RESP -> IDLE unconditionally.
  - A new request is accepted no earlier than the cycle after RESP.
- Wrap-around: addr+1 wraps modulo 2**ADDR_WIDTH (0xFF -> 0x00), matching the memory's second write byte.
- Reset mid-operation: next state is IDLE and mem_we is 0 from the next cycle. The in-flight access is abandoned with no rsp_valid. A WR cycle already clocked stays committed.
- Simultaneous rst and req_valid: rst wins; the request is not accepted.
- mem_w_addr and mem_w_data are 0 outside WR.

Test Plan:
- Preload mem[0x0F]=0x01, mem[0x10]=0x02; wide load at 0x0F -> rsp_valid 4 cycles after accept, rsp_rdata=0x0201, mem_we never asserted.
- Wide store at 0x20 with data 0xBEEF -> mem_we high for exactly 1 cycle; mem[0x20]=0xEF, mem[0x21]=0xBE; a following wide load at 0x20 returns 0xBEEF.
- Preload mem[0x31]=0x77; byte store at 0x30 with data 0x005A -> mem[0x30]=0x5A, mem[0x31]=0x77; rsp_valid 4 cycles after accept.
- Byte load at 0x10 (value 0x02) -> rsp_rdata=0x0002 after 3 cycles; a subsequent wide store leaves rsp_rdata at 0x0002.
- Wrap: mem[0xFF]=0x11, mem[0x00]=0x05; wide load at 0xFF -> 0x0511; byte store 0x33 at 0xFF -> mem[0x00] stays 0x05.
- Assert rst during RD1 of a wide load, with req_valid held high throughout -> no rsp_valid, mem_we=0, req_ready=1 the cycle after rst drops; the held request is then accepted and completes normally.
